// File: rtl/opamp_power_sequencer_if.sv
// Bundle of the pin-decode side and analog-macro side signals of the opamp
// power sequencer. The pin-decode logic (or a bench) uses the master modport,
// and the sequencer uses the slave modport.
interface opamp_power_sequencer_if;
   logic [1:0] req;        // per-opamp enable request (level)
   logic       cfg_valid;  // trim write request
   logic [3:0] cfg_trim;   // trim write data
   logic       cfg_ready;  // trim write accepted when cfg_valid && cfg_ready
   logic       bias_en;    // bias generator enable
   logic [3:0] bias_trim;  // bias trim code
   logic [1:0] amp_en;     // per-opamp enable
   logic [1:0] amp_ready;  // opamp enabled and sequence complete
   logic       busy;       // sequence in progress

   modport master (
      output req, cfg_valid, cfg_trim,
      input  cfg_ready, bias_en, bias_trim, amp_en, amp_ready, busy
   );

   modport slave (
      input  req, cfg_valid, cfg_trim,
      output cfg_ready, bias_en, bias_trim, amp_en, amp_ready, busy
   );
endinterface

// File: rtl/opamp_power_sequencer.sv
// Power and bias sequencer for two opamps that share one bias generator.
// The bias comes up first and settles, then the requested opamps are enabled.
// Teardown disables the opamps, then holds the bias for a drain time before
// turning it off. Trim writes in RUN mute the opamps and force a full re-settle.
//
// Optional feature: define OPAMP_SEQ_STAGGER_EN to enable the opamps one at a
// time, lowest index first, with STAGGER_CYC between enables. If it is left
// undefined, every requested opamp is enabled together and STAGE is never
// entered.
module opamp_power_sequencer #(
   parameter int unsigned SETTLE_CYC  = 64,    // bias settle time, 1..255
   parameter int unsigned STAGGER_CYC = 16,    // spacing between opamp enables, 1..255
   parameter int unsigned DRAIN_CYC   = 8,     // last opamp off to bias off, 1..255
   parameter logic [3:0]  TRIM_RST    = 4'h8   // bias_trim reset value
) (
   input logic                   clk,
   input logic                   rst,
   opamp_power_sequencer_if.slave bus
);

   // The counter runs from 0 after a state entry. A delay of N edges ends
   // on the edge where the counter holds N-1.
   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] STAGGER_LAST = 8'(STAGGER_CYC - 1);
   localparam logic [7:0] DRAIN_LAST   = 8'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_BIAS,
      ST_STAGE,
      ST_RUN,
      ST_DRAIN
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       bias_en_q, bias_en_d;
   logic [3:0] trim_q, trim_d;
   logic [1:0] amp_en_q, amp_en_d;

   logic       cfg_ready_w;
   logic       cfg_fire;
   logic [1:0] kept;      // enabled opamps that are still requested
   logic       restart;   // restart the stagger window without a state change

   // Selects the lowest-index set bit. Zero input gives zero output.
   function automatic logic [1:0] lowest_bit(input logic [1:0] v);
      if (v[0]) return 2'b01;
      if (v[1]) return 2'b10;
      return 2'b00;
   endfunction

   // Trim writes are only taken while the analog side is idle or stable.
   assign cfg_ready_w = (state_q == ST_OFF) || (state_q == ST_RUN);
   assign cfg_fire    = bus.cfg_valid && cfg_ready_w;
   assign kept        = bus.req & amp_en_q;

   // Next-state, counter and registered-output logic.
   always_comb begin
      // NOTE: every variable gets a default here so that no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q + 8'd1;
      bias_en_d = bias_en_q;
      trim_d    = trim_q;
      amp_en_d  = amp_en_q;
      restart   = 1'b0;

      unique case (state_q)
         ST_OFF: begin
            bias_en_d = 1'b0;
            amp_en_d  = 2'b00;
            cnt_d     = 8'd0;
            if (cfg_fire) trim_d = bus.cfg_trim;
            if (bus.req != 2'b00) begin
               bias_en_d = 1'b1;
               state_d   = ST_BIAS;
            end
         end

         ST_BIAS: begin
            bias_en_d = 1'b1;
            amp_en_d  = 2'b00;
            if (bus.req == 2'b00) begin
               // The opamps were never on, so the bias can drop without a drain.
               bias_en_d = 1'b0;
               state_d   = ST_OFF;
            end else if (cnt_q == SETTLE_LAST) begin
`ifdef OPAMP_SEQ_STAGGER_EN
               amp_en_d = lowest_bit(bus.req);
               state_d  = ((bus.req & ~amp_en_d) != 2'b00) ? ST_STAGE : ST_RUN;
`else
               amp_en_d = bus.req;
               state_d  = ST_RUN;
`endif
            end
         end

         ST_STAGE: begin
            bias_en_d = 1'b1;
            amp_en_d  = kept;
            if (bus.req == 2'b00) begin
               amp_en_d = 2'b00;
               state_d  = ST_DRAIN;
            end else begin
               if (cnt_q == STAGGER_LAST) begin
                  amp_en_d = kept | lowest_bit(bus.req & ~kept);
                  restart  = 1'b1;
               end
               if (((bus.req & ~amp_en_d) == 2'b00) && (amp_en_d != 2'b00))
                  state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            bias_en_d = 1'b1;
            cnt_d     = 8'd0;
            if (cfg_fire) begin
               // A trim change takes priority over any req change in the same cycle.
               // The opamps are muted and the bias is fully re-settled.
               trim_d   = bus.cfg_trim;
               amp_en_d = 2'b00;
               state_d  = ST_BIAS;
            end else if (bus.req == 2'b00) begin
               amp_en_d = 2'b00;
               state_d  = ST_DRAIN;
            end else begin
`ifdef OPAMP_SEQ_STAGGER_EN
               amp_en_d = kept;
               if ((bus.req & ~kept) != 2'b00) state_d = ST_STAGE;
`else
               amp_en_d = bus.req;
`endif
            end
         end

         ST_DRAIN: begin
            bias_en_d = 1'b1;
            amp_en_d  = 2'b00;
            if (bus.req != 2'b00) begin
               // The bias is still up and settled, so staging resumes directly.
`ifdef OPAMP_SEQ_STAGGER_EN
               state_d = ST_STAGE;
`else
               amp_en_d = bus.req;
               state_d  = ST_RUN;
`endif
            end else if (cnt_q == DRAIN_LAST) begin
               bias_en_d = 1'b0;
               state_d   = ST_OFF;
            end
         end

         default: begin
            bias_en_d = 1'b0;
            amp_en_d  = 2'b00;
            state_d   = ST_OFF;
         end
      endcase

      // The counter restarts on every state entry and on every stagger enable.
      if ((state_d != state_q) || restart) cnt_d = 8'd0;
   end

   // State and registered outputs. Reset is asynchronous and active-high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_OFF;
         cnt_q     <= 8'd0;
         bias_en_q <= 1'b0;
         trim_q    <= TRIM_RST;
         amp_en_q  <= 2'b00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples the pre-edge values of the others.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bias_en_q <= bias_en_d;
         trim_q    <= trim_d;
         amp_en_q  <= amp_en_d;
      end
   end

   assign bus.cfg_ready = cfg_ready_w;
   assign bus.bias_en   = bias_en_q;
   assign bus.bias_trim = trim_q;
   assign bus.amp_en    = amp_en_q;
   assign bus.amp_ready = (state_q == ST_RUN) ? amp_en_q : 2'b00;
   assign bus.busy      = (state_q == ST_BIAS) || (state_q == ST_STAGE) ||
                          (state_q == ST_DRAIN);

endmodule

// File: tb/tb_opamp_power_sequencer.sv
// Self-checking bench for opamp_power_sequencer. Expected output snapshots are
// queued by cycle number when stimulus is driven. They are compared at the
// falling edge of that cycle. Expectations follow OPAMP_SEQ_STAGGER_EN when
// it is defined.
module tb_opamp_power_sequencer;

   localparam int SETTLE  = 64;
   localparam int STAGGER = 16;
   localparam int DRAIN   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   opamp_power_sequencer_if bus ();

   opamp_power_sequencer #(
      .SETTLE_CYC (SETTLE),
      .STAGGER_CYC(STAGGER),
      .DRAIN_CYC  (DRAIN),
      .TRIM_RST   (4'h8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int         cyc;
      string      tag;
      logic       bias;
      logic [1:0] amp;
      logic [1:0] rdy;
      logic [3:0] trim;
      logic       busy;
      logic       cfgr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Adds an expected snapshot for cycle c, keeping the queue ordered by cycle.
   task automatic expect_at(input int c, input string tag, input logic b, input logic [1:0] a,
                            input logic [1:0] r, input logic [3:0] t, input logic bz,
                            input logic cr);
      exp_t e;
      int   i;
      e.cyc = c; e.tag = tag; e.bias = b; e.amp = a; e.rdy = r;
      e.trim = t; e.busy = bz; e.cfgr = cr;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endtask

   task automatic compare_snapshot(input exp_t e);
      check({e.tag, "/bias_en"},   bus.bias_en,   e.bias);
      check({e.tag, "/amp_en"},    bus.amp_en,    e.amp);
      check({e.tag, "/amp_ready"}, bus.amp_ready, e.rdy);
      check({e.tag, "/bias_trim"}, bus.bias_trim, e.trim);
      check({e.tag, "/busy"},      bus.busy,      e.busy);
      check({e.tag, "/cfg_ready"}, bus.cfg_ready, e.cfgr);
   endtask

   // Compares the queued snapshots that fall due this cycle, away from the active edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc < cyc) check({mon_e.tag, "/cycle"}, cyc, mon_e.cyc);
         else                 compare_snapshot(mon_e);
      end
   end

   // Advances to just after the edge that makes cyc equal n.
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0, e1, e2, f, t, g, h, t_run;
      bus.req       = 2'b00;
      bus.cfg_valid = 1'b0;
      bus.cfg_trim  = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("reset/bias_en",   bus.bias_en,   1'b0);
      check("reset/amp_en",    bus.amp_en,    2'b00);
      check("reset/bias_trim", bus.bias_trim, 4'h8);
      check("reset/busy",      bus.busy,      1'b0);
      check("reset/cfg_ready", bus.cfg_ready, 1'b1);
      goto(cyc + 2);

      // Single opamp: settle, run, drop, drain
      e0 = cyc + 1;
      bus.req = 2'b01;
      expect_at(e0,              "b_on",       1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e0 + SETTLE - 1, "b_presettle",1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e0 + SETTLE,     "b_amp",      1, 2'b01, 2'b01, 4'h8, 0, 1);
      goto(e0 + SETTLE + 5);
      e1 = cyc + 1;
      bus.req = 2'b00;
      expect_at(e1,             "b_drop",  1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e1 + DRAIN - 1, "b_drain", 1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e1 + DRAIN,     "b_off",   0, 2'b00, 2'b00, 4'h8, 0, 1);
      goto(e1 + DRAIN + 2);

      // Both opamps, then drop and re-request during drain
      e0 = cyc + 1;
      bus.req = 2'b11;
`ifdef OPAMP_SEQ_STAGGER_EN
      expect_at(e0 + SETTLE,               "c_first", 1, 2'b01, 2'b00, 4'h8, 1, 0);
      expect_at(e0 + SETTLE + STAGGER - 1, "c_gap",   1, 2'b01, 2'b00, 4'h8, 1, 0);
      expect_at(e0 + SETTLE + STAGGER,     "c_both",  1, 2'b11, 2'b11, 4'h8, 0, 1);
      t_run = e0 + SETTLE + STAGGER;
`else
      expect_at(e0 + SETTLE - 1, "c_pre",  1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e0 + SETTLE,     "c_both", 1, 2'b11, 2'b11, 4'h8, 0, 1);
      t_run = e0 + SETTLE;
`endif
      goto(t_run + 3);
      e1 = cyc + 1;
      bus.req = 2'b00;
      expect_at(e1, "c_drop", 1, 2'b00, 2'b00, 4'h8, 1, 0);
      goto(e1 + 2);
      e2 = cyc + 1;
      bus.req = 2'b10;
`ifdef OPAMP_SEQ_STAGGER_EN
      expect_at(e2,               "c_restage", 1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e2 + STAGGER - 1, "c_wait",    1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(e2 + STAGGER,     "c_amp1",    1, 2'b10, 2'b10, 4'h8, 0, 1);
      t_run = e2 + STAGGER;
`else
      expect_at(e2, "c_amp1", 1, 2'b10, 2'b10, 4'h8, 0, 1);
      t_run = e2;
`endif

      // Swap the requested opamp in RUN
      goto(t_run + 3);
      f = cyc + 1;
      bus.req = 2'b01;
`ifdef OPAMP_SEQ_STAGGER_EN
      expect_at(f,           "d_swap", 1, 2'b00, 2'b00, 4'h8, 1, 0);
      expect_at(f + STAGGER, "d_new",  1, 2'b01, 2'b01, 4'h8, 0, 1);
      t_run = f + STAGGER;
`else
      expect_at(f, "d_new", 1, 2'b01, 2'b01, 4'h8, 0, 1);
      t_run = f;
`endif

      // Trim write in RUN: mute, re-settle, re-enable
      goto(t_run + 3);
      t = cyc + 1;
      bus.cfg_valid = 1'b1;
      bus.cfg_trim  = 4'h3;
      expect_at(t, "d_trim", 1, 2'b00, 2'b00, 4'h3, 1, 0);
      goto(t);
      bus.cfg_valid = 1'b0;
      goto(t + 9);
      bus.cfg_valid = 1'b1;
      bus.cfg_trim  = 4'h9;
      expect_at(t + 10, "d_ignored", 1, 2'b00, 2'b00, 4'h3, 1, 0);
      goto(t + 10);
      bus.cfg_valid = 1'b0;
      expect_at(t + SETTLE - 1, "d_muted", 1, 2'b00, 2'b00, 4'h3, 1, 0);
      expect_at(t + SETTLE,     "d_back",  1, 2'b01, 2'b01, 4'h3, 0, 1);
      goto(t + SETTLE + 2);
      g = cyc + 1;
      bus.req = 2'b00;
      expect_at(g + DRAIN, "d_off", 0, 2'b00, 2'b00, 4'h3, 0, 1);
      goto(g + DRAIN + 1);

      // Trim write in OFF
      h = cyc + 1;
      bus.cfg_valid = 1'b1;
      bus.cfg_trim  = 4'h5;
      expect_at(h, "d_trim_off", 0, 2'b00, 2'b00, 4'h5, 0, 1);
      goto(h);
      bus.cfg_valid = 1'b0;
      expect_at(h + 1, "d_still_off", 0, 2'b00, 2'b00, 4'h5, 0, 1);
      goto(h + 2);

      // Request withdrawn during settle: no drain, opamp never enabled
      e0 = cyc + 1;
      bus.req = 2'b01;
      expect_at(e0 + 9, "e_bias", 1, 2'b00, 2'b00, 4'h5, 1, 0);
      goto(e0 + 9);
      bus.req = 2'b00;
      expect_at(e0 + 10,     "e_abort", 0, 2'b00, 2'b00, 4'h5, 0, 1);
      expect_at(e0 + SETTLE, "e_never", 0, 2'b00, 2'b00, 4'h5, 0, 1);
      goto(e0 + SETTLE + 2);

      // Asynchronous reset in the middle of BIAS
      e0 = cyc + 1;
      bus.req = 2'b01;
      expect_at(e0, "a_bias", 1, 2'b00, 2'b00, 4'h5, 1, 0);
      goto(e0 + 10);
      #2 rst = 1'b1;
      #1;
      check("a_rst/bias_en",   bus.bias_en,   1'b0);
      check("a_rst/amp_en",    bus.amp_en,    2'b00);
      check("a_rst/bias_trim", bus.bias_trim, 4'h8);
      check("a_rst/busy",      bus.busy,      1'b0);
      check("a_rst/cfg_ready", bus.cfg_ready, 1'b1);
      check("a_rst/amp_ready", bus.amp_ready, 2'b00);
      bus.req = 2'b00;
      @(posedge clk);
      #1 rst = 1'b0;
      expect_at(cyc + 2, "a_idle", 0, 2'b00, 2'b00, 4'h8, 0, 1);
      goto(cyc + 4);

      // Any snapshot still queued was never reached.
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check({mon_e.tag, "/reached"}, cyc, mon_e.cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
